// File: rtl/raster_pkg.sv
// Shared rasterizer types and screen constants for the bounding-box scan scheduler.
package raster_pkg;

   localparam int CW    = 12;   // signed input coordinate width
   localparam int SCR_W = 640;  // screen width in pixels
   localparam int SCR_H = 480;  // screen height in pixels
   localparam int ID_W  = 8;    // triangle tag width
   localparam int XW    = 10;   // fragment x width
   localparam int YW    = 9;    // fragment y width

   typedef logic signed [CW-1:0] coord_t;
   typedef logic        [XW-1:0] px_x_t;
   typedef logic        [YW-1:0] px_y_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLAMP = 2'd1,
      SCAN  = 2'd2
   } state_e;

endpackage

// File: rtl/bbox_clamp.sv
// Clamps a signed bounding box to the screen on both axes in parallel and
// flags boxes that are empty after clamping (inverted or fully off-screen).
module bbox_clamp #(
   parameter int CW    = 12,
   parameter int SCR_W = 640,
   parameter int SCR_H = 480,
   parameter int XW    = 10,
   parameter int YW    = 9
) (
   input  logic signed [CW-1:0] min_x_i,
   input  logic signed [CW-1:0] max_x_i,
   input  logic signed [CW-1:0] min_y_i,
   input  logic signed [CW-1:0] max_y_i,
   output logic        [XW-1:0] cmin_x_o,
   output logic        [XW-1:0] cmax_x_o,
   output logic        [YW-1:0] cmin_y_o,
   output logic        [YW-1:0] cmax_y_o,
   output logic                 empty_o
);

   localparam logic signed [CW-1:0] XMAX = CW'(SCR_W - 1);
   localparam logic signed [CW-1:0] YMAX = CW'(SCR_H - 1);

   logic signed [CW-1:0] lo_x, hi_x, lo_y, hi_y;

   // Per-axis clamp in full signed width; only a non-empty result is narrowed,
   // where the clamp guarantees it fits the pixel widths.
   always_comb begin
      lo_x     = min_x_i[CW-1] ? '0 : min_x_i;
      lo_y     = min_y_i[CW-1] ? '0 : min_y_i;
      hi_x     = (max_x_i > XMAX) ? XMAX : max_x_i;
      hi_y     = (max_y_i > YMAX) ? YMAX : max_y_i;
      empty_o  = (lo_x > hi_x) || (lo_y > hi_y);
      cmin_x_o = XW'(lo_x);
      cmax_x_o = XW'(hi_x);
      cmin_y_o = YW'(lo_y);
      cmax_y_o = YW'(hi_y);
   end

endmodule

// File: rtl/bbox_scan_sched.sv
// Accepts one bounding box at a time, clamps it to the screen, drops empty
// boxes and walks the rest row-major, one fragment per downstream handshake.
module bbox_scan_sched #(
   parameter int CW    = raster_pkg::CW,
   parameter int SCR_W = raster_pkg::SCR_W,
   parameter int SCR_H = raster_pkg::SCR_H,
   parameter int ID_W  = raster_pkg::ID_W,
   parameter int XW    = raster_pkg::XW,
   parameter int YW    = raster_pkg::YW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [CW-1:0] in_min_x,
   input  logic signed [CW-1:0] in_max_x,
   input  logic signed [CW-1:0] in_min_y,
   input  logic signed [CW-1:0] in_max_y,
   input  logic [ID_W-1:0]      in_id,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XW-1:0]        out_x,
   output logic [YW-1:0]        out_y,
   output logic [ID_W-1:0]      out_id,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 busy,
   output logic [15:0]          drop_cnt
);

   import raster_pkg::*;

   state_e               state_q;
   logic signed [CW-1:0] min_x_q, max_x_q, min_y_q, max_y_q;
   logic [ID_W-1:0]      id_q;
   logic [XW-1:0]        cmin_x_q, cmax_x_q, cur_x_q, cur_x_d;
   logic [YW-1:0]        cmin_y_q, cmax_y_q, cur_y_q, cur_y_d;
   logic                 in_ready_q, out_valid_q, first_q, last_q, busy_q;
   logic [15:0]          drop_q;
   logic                 done_d;

   logic [XW-1:0]        c_min_x, c_max_x;
   logic [YW-1:0]        c_min_y, c_max_y;
   logic                 c_empty;

   bbox_clamp #(
      .CW(CW), .SCR_W(SCR_W), .SCR_H(SCR_H), .XW(XW), .YW(YW)
   ) u_clamp (
      .min_x_i (min_x_q),
      .max_x_i (max_x_q),
      .min_y_i (min_y_q),
      .max_y_i (max_y_q),
      .cmin_x_o(c_min_x),
      .cmax_x_o(c_max_x),
      .cmin_y_o(c_min_y),
      .cmax_y_o(c_max_y),
      .empty_o (c_empty)
   );

   // Next raster position: step along the row, wrap to the next row, or finish.
   always_comb begin
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      done_d  = 1'b0;
      if (cur_x_q < cmax_x_q) begin
         cur_x_d = cur_x_q + XW'(1);
      end else if (cur_y_q < cmax_y_q) begin
         cur_x_d = cmin_x_q;
         cur_y_d = cur_y_q + YW'(1);
      end else begin
         done_d = 1'b1;
      end
   end

   // Scheduler FSM; every output is a flop so nothing changes during a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         drop_q      <= '0;
         min_x_q     <= '0;
         max_x_q     <= '0;
         min_y_q     <= '0;
         max_y_q     <= '0;
         id_q        <= '0;
         cmin_x_q    <= '0;
         cmax_x_q    <= '0;
         cmin_y_q    <= '0;
         cmax_y_q    <= '0;
         cur_x_q     <= '0;
         cur_y_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  min_x_q    <= in_min_x;
                  max_x_q    <= in_max_x;
                  min_y_q    <= in_min_y;
                  max_y_q    <= in_max_y;
                  id_q       <= in_id;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= CLAMP;
               end
            end
            CLAMP: begin
               if (c_empty) begin
                  if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  cmin_x_q    <= c_min_x;
                  cmax_x_q    <= c_max_x;
                  cmin_y_q    <= c_min_y;
                  cmax_y_q    <= c_max_y;
                  cur_x_q     <= c_min_x;
                  cur_y_q     <= c_min_y;
                  out_valid_q <= 1'b1;
                  first_q     <= 1'b1;
                  last_q      <= (c_min_x == c_max_x) && (c_min_y == c_max_y);
                  state_q     <= SCAN;
               end
            end
            SCAN: begin
               if (out_ready) begin
                  if (done_d) begin
                     out_valid_q <= 1'b0;
                     first_q     <= 1'b0;
                     last_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     cur_x_q <= cur_x_d;
                     cur_y_q <= cur_y_d;
                     first_q <= 1'b0;
                     last_q  <= (cur_x_d == cmax_x_q) && (cur_y_d == cmax_y_q);
                  end
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_x     = cur_x_q;
   assign out_y     = cur_y_q;
   assign out_id    = id_q;
   assign out_first = first_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_bbox_scan_sched.sv
// Directed bench for bbox_scan_sched: clamp, drop, raster order, stalls, reset.
module tb_bbox_scan_sched;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [11:0] in_min_x, in_max_x, in_min_y, in_max_y;
   logic [7:0]        in_id;
   logic              out_valid;
   logic              out_ready;
   logic [9:0]        out_x;
   logic [8:0]        out_y;
   logic [7:0]        out_id;
   logic              out_first, out_last, busy;
   logic [15:0]       drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   bbox_scan_sched dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_min_x(in_min_x), .in_max_x(in_max_x),
      .in_min_y(in_min_y), .in_max_y(in_max_y),
      .in_id(in_id),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_id(out_id),
      .out_first(out_first), .out_last(out_last),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one edge, then sample away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_box(input int x0, input int y0, input int x1, input int y1, input int id);
      in_min_x = 12'(x0);
      in_min_y = 12'(y0);
      in_max_x = 12'(x1);
      in_max_y = 12'(y1);
      in_id    = 8'(id);
   endtask

   // handshake one box, land in the clamp cycle and check it is quiet
   task automatic send_box(input string tag, input int x0, input int y0,
                           input int x1, input int y1, input int id);
      check({tag, "_rdy"}, int'(in_ready), 1);
      set_box(x0, y0, x1, y1, id);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_clamp"}, int'({out_valid, in_ready, busy}), 3'b001);
   endtask

   // packed {valid, first, last, x, y} plus the owning tag
   task automatic frag(input string tag, input int x, input int y,
                       input int f, input int l, input int id);
      int e;
      e = (1 << 21) | (f << 20) | (l << 19) | (x << 9) | y;
      check(tag, int'({out_valid, out_first, out_last, out_x, out_y}), e);
      check({tag, "_id"}, int'(out_id), id);
   endtask

   task automatic idle_chk(input string tag, input int drops);
      check({tag, "_idle"}, int'({out_valid, in_ready, busy}), 3'b010);
      check({tag, "_drop"}, int'(drop_cnt), drops);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      set_box(0, 0, 0, 0, 0);
      tick(); tick();
      rst = 1'b0;
      check("rst_io", int'({in_ready, out_valid, busy, out_first, out_last}), 5'b10000);
      check("rst_xy", int'({out_x, out_y, out_id}), 0);
      check("rst_drop", int'(drop_cnt), 0);

      // basic 2x2 raster: first fragment one cycle after the clamp cycle
      send_box("b1", 2, 3, 3, 4, 8'h11);
      tick();
      frag("b1_f0", 2, 3, 1, 0, 8'h11); tick();
      frag("b1_f1", 3, 3, 0, 0, 8'h11); tick();
      frag("b1_f2", 2, 4, 0, 0, 8'h11); tick();
      frag("b1_f3", 3, 4, 0, 1, 8'h11); tick();
      idle_chk("b1", 0);

      // negative mins clamp to 0; next request is held while busy
      send_box("b2", -5, -2, 1, 0, 8'h22);
      set_box(700, 10, 800, 20, 8'h33);
      in_valid = 1'b1;
      tick();
      frag("b2_f0", 0, 0, 1, 0, 8'h22);
      check("b2_busy_rdy", int'(in_ready), 0);
      tick();
      frag("b2_f1", 1, 0, 0, 1, 8'h22); tick();
      idle_chk("b2", 0);

      // held off-screen box is accepted now and dropped
      tick();
      in_valid = 1'b0;
      check("b3_clamp", int'({out_valid, in_ready, busy}), 3'b001);
      tick();
      idle_chk("b3", 1);

      // inverted box is dropped too
      send_box("b4", 5, 5, 4, 9, 8'h44);
      tick();
      idle_chk("b4", 2);

      // screen corner with stalls: every fragment held for one stalled cycle
      send_box("b5", 638, 478, 700, 500, 8'h55);
      tick();
      frag("b5_f0", 638, 478, 1, 0, 8'h55); out_ready = 1'b0; tick();
      frag("b5_h0", 638, 478, 1, 0, 8'h55); out_ready = 1'b1; tick();
      frag("b5_f1", 639, 478, 0, 0, 8'h55); out_ready = 1'b0; tick();
      frag("b5_h1", 639, 478, 0, 0, 8'h55); out_ready = 1'b1; tick();
      frag("b5_f2", 638, 479, 0, 0, 8'h55); out_ready = 1'b0; tick();
      frag("b5_h2", 638, 479, 0, 0, 8'h55); out_ready = 1'b1; tick();
      frag("b5_f3", 639, 479, 0, 1, 8'h55); out_ready = 1'b0; tick();
      frag("b5_h3", 639, 479, 0, 1, 8'h55); out_ready = 1'b1; tick();
      idle_chk("b5", 2);

      // single pixel: first and last together
      send_box("b6", 10, 10, 10, 10, 8'h66);
      tick();
      frag("b6_f0", 10, 10, 1, 1, 8'h66); tick();
      idle_chk("b6", 2);

      // reset in the middle of a 10x10 scan
      send_box("b7", 0, 0, 9, 9, 8'h77);
      tick();
      for (int i = 0; i < 5; i++) begin
         frag("b7_f", i, 0, (i == 0) ? 1 : 0, 0, 8'h77);
         tick();
      end
      frag("b7_f5", 5, 0, 0, 0, 8'h77);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("b7_rst_io", int'({out_valid, busy, in_ready}), 3'b001);
      check("b7_rst_drop", int'(drop_cnt), 0);

      // next box scans from its own clamped origin
      send_box("b8", 3, 7, 4, 7, 8'h88);
      tick();
      frag("b8_f0", 3, 7, 1, 0, 8'h88); tick();
      frag("b8_f1", 4, 7, 0, 1, 8'h88); tick();
      idle_chk("b8", 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bbox_scan_sched.md
Name: bbox_scan_sched

Overview:
- Schedules triangle bounding boxes onto the fragment-generation stage of the triangle rasterizer.
- Accepts one integer-pixel bounding box at a time over a valid/ready handshake.
- Clamps the box to the screen and drops empty or fully off-screen boxes.
- Walks the clamped box in row-major order, emitting one fragment coordinate per downstream handshake with first/last tags, so a single scan datapath is shared across a stream of triangles.

Parameters:
- CW, 12: signed two's-complement input coordinate width.
- SCR_W, 640: screen width in pixels; valid x range is 0..SCR_W-1.
- SCR_H, 480: screen height in pixels; valid y range is 0..SCR_H-1.
- ID_W, 8: triangle tag width.
- XW, 10: output x width.
- YW, 9: output y width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  bounding-box request valid
- in_ready  out  1  scheduler can accept a box
- in_min_x  in  CW  box min x, signed
- in_max_x  in  CW  box max x, signed
- in_min_y  in  CW  box min y, signed
- in_max_y  in  CW  box max y, signed
- in_id  in  ID_W  triangle tag
- out_valid  out  1  fragment valid
- out_ready  in  1  downstream accepts fragment
- out_x  out  XW  fragment x
- out_y  out  YW  fragment y
- out_id  out  ID_W  tag of the owning box
- out_first  out  1  first fragment of the box
- out_last  out  1  last fragment of the box
- busy  out  1  not IDLE
- drop_cnt  out  16  saturating count of dropped boxes

Behaviour:
- Reset: rst (synchronous, active-high) on clk. All outputs are 0 after reset except in_ready, which is 1. State goes to IDLE and drop_cnt clears.
- States:
  - IDLE: in_ready=1. When in_valid & in_ready, capture all in_* fields and go to CLAMP.
  - CLAMP (exactly 1 cycle, in_ready=0):
    - cmin = max(min, 0).
    - cmax = min(max, SCR-1), computed per axis in signed CW arithmetic.
    - Box is empty if cmin > cmax on either axis. This covers inverted input boxes and boxes fully off-screen.
    - Empty box: drop_cnt += 1, saturating at 16'hFFFF, then return to IDLE. No fragment is emitted.
    - Otherwise: cur_x = cmin_x, cur_y = cmin_y, go to SCAN.
  - SCAN: out_valid=1, in_ready=0.
    - out_x = cur_x and out_y = cur_y, truncated to XW/YW; clamping guarantees the values fit.
    - out_first = (cur_x == cmin_x && cur_y == cmin_y).
    - out_last = (cur_x == cmax_x && cur_y == cmax_y).
    - On out_valid & out_ready:
      - if cur_x < cmax_x: cur_x++.
      - else if cur_y < cmax_y: cur_x = cmin_x, cur_y++.
      - else (last fragment): go to IDLE.
    - While out_ready=0, every out_* signal holds stable.
- Latency and throughput:
  - The first out_valid is asserted 2 cycles after the accept edge.
  - A box of W×H fragments emits W*H fragments at 1 per cycle under continuous out_ready.
  - One IDLE cycle separates consecutive boxes.
- Single-pixel box: a 1×1 box asserts out_first and out_last together on the same fragment.
- busy = (state != IDLE).
- Reset mid-SCAN or mid-CLAMP: the box is abandoned and out_valid=0 on the cycle after rst. No partial completion is signalled.
- in_valid while busy is ignored (in_ready=0). The upstream holds the request; no loss occurs.
- Boundary values: cmax equal to SCR_W-1 or SCR_H-1 is legal, and increments never exceed it. A negative min combined with a negative max is always dropped.

Decomposition:
- Shared package raster_pkg holds:
  - SCR_W and SCR_H constants.
  - Coordinate typedefs: signed CW, unsigned XW/YW.
  - State enum {IDLE, CLAMP, SCAN}.
- Sub-module bbox_clamp: combinational per-axis clamp plus empty detect. It is instantiated once and processes both axes in parallel.

Test Plan:
- Box (2,3)-(3,4), out_ready=1 -> fragments (2,3)F,(3,3),(2,4),(3,4)L on consecutive cycles; first out_valid 2 cycles after accept.
- Box (-5,-2)-(1,0) -> clamped to (0,0)-(1,0); emits (0,0)F,(1,0)L; drop_cnt unchanged.
- Box (700,10)-(800,20), then inverted box (5,5)-(4,9) -> no out_valid; drop_cnt = 2; in_ready back to 1 after each CLAMP.
- Box (638,478)-(700,500) with out_ready toggling 1010... -> emits (638,478)F,(639,478),(638,479),(639,479)L; outputs held stable during stalls.
- Single pixel (10,10)-(10,10) -> one fragment with out_first=out_last=1.
- rst asserted mid-scan of (0,0)-(9,9) after 5 fragments -> out_valid=0 and busy=0 next cycle; drop_cnt=0; next accepted box scans from its own cmin.
